// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory write-port arbiter.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Increment an index modulo n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) == n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

// File: rtl/mem_wr_arb_rr_pick.sv
// Round-robin priority picker: grants the first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found_s;
    logic [IW-1:0] j_s;

    // Scan from ptr upward and keep the first hit.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        j_s     = '0;
        for (int k = 0; k < N; k++) begin
            j_s = IW'((32'(ptr) + 32'(k)) % 32'(N));
            if (!found_s && req[j_s]) begin
                found_s  = 1'b1;
                gnt[j_s] = 1'b1;
                idx      = j_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_wr_arb.sv
// N-to-1 write arbiter onto a single memory port A with round-robin fairness.
// Burst locking is built only when MEM_WR_ARB_BURST_EN is defined.
module mem_wr_arb
    import mem_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 weA,
    output logic                 enA,
    output logic [AW-1:0]        addrA,
    output logic [WIDTH-1:0]     dinA,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
);

    logic [NREQ-1:0]  pick_gnt_s;
    logic [IW-1:0]    pick_idx_s;
    logic [NREQ-1:0]  ready_raw_s;
    logic [NREQ-1:0]  ready_s;
    logic [IW-1:0]    win_s;
    logic             beat_s;

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             en_q, en_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [IW-1:0]    gid_q, gid_d;

`ifdef MEM_WR_ARB_BURST_EN
    arb_state_t       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
`else
    logic             unused_last_s;
    assign unused_last_s = ^req_last;
`endif

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Accept selection, beat detection and next-state for port A and arbitration.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        en_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        gid_d       = gid_q;
        ready_raw_s = '0;
        win_s       = pick_idx_s;
`ifdef MEM_WR_ARB_BURST_EN
        state_d     = state_q;
        owner_d     = owner_q;
        case (state_q)
            IDLE: ready_raw_s = pick_gnt_s;
            LOCK: begin
                win_s                = owner_q;
                ready_raw_s[owner_q] = req_valid[owner_q];
            end
            default: begin
                ready_raw_s = '0;
                state_d     = IDLE;
            end
        endcase
`else
        ready_raw_s = pick_gnt_s;
`endif
        ready_s = rst_n ? ready_raw_s : '0;
        beat_s  = |(req_valid & ready_s);

        if (beat_s) begin
            en_d  = 1'b1;
            gid_d = win_s;
            for (int i = 0; i < NREQ; i++) begin
                if (win_s == IW'(i)) begin
                    addr_d = req_addr[i*AW +: AW];
                    din_d  = req_data[i*WIDTH +: WIDTH];
                end else begin
                    addr_d = addr_d;
                end
            end
`ifdef MEM_WR_ARB_BURST_EN
            // A non-final beat pins arbitration to this requester until its last beat.
            if (req_last[win_s]) begin
                state_d  = IDLE;
                rr_ptr_d = IW'(wrap_inc(32'(win_s), 32'(NREQ)));
            end else begin
                state_d  = LOCK;
                owner_d  = win_s;
            end
`else
            rr_ptr_d = IW'(wrap_inc(32'(win_s), 32'(NREQ)));
`endif
        end else begin
            en_d = 1'b0;
        end
    end

    // State and port A registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gid_q    <= '0;
`ifdef MEM_WR_ARB_BURST_EN
            state_q  <= IDLE;
            owner_q  <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gid_q    <= gid_d;
`ifdef MEM_WR_ARB_BURST_EN
            state_q  <= state_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign req_ready = ready_s;
    assign enA       = en_q;
    assign weA       = en_q;
    assign addrA     = addr_q;
    assign dinA      = din_q;
    assign grant_id  = gid_q;
`ifdef MEM_WR_ARB_BURST_EN
    assign busy      = (state_q == LOCK);
`else
    assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wr_arb.sv
// Directed-vector bench for mem_wr_arb (NREQ=4, WIDTH=32, DEPTH=512).
// Burst scenarios are compiled when MEM_WR_ARB_BURST_EN is defined.
module tb_mem_wr_arb;

    localparam int AW = 9;
`ifdef MEM_WR_ARB_BURST_EN
    localparam logic BURST = 1'b1;
`else
    localparam logic BURST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [35:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         weA, enA, busy;
    logic [8:0]   addrA;
    logic [31:0]  dinA;
    logic [1:0]   grant_id;

    logic [8:0]   addr_tb [4];
    logic [31:0]  data_tb [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = addr_tb[g];
        assign req_data[g*32 +: 32] = data_tb[g];
    end

    mem_wr_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .weA       (weA),
        .enA       (enA),
        .addrA     (addrA),
        .dinA      (dinA),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int who);
        chk({tag, ".enA"}, 64'(enA), 64'd1);
        chk({tag, ".weA"}, 64'(weA), 64'd1);
        chk({tag, ".gid"}, 64'(grant_id), 64'(who));
        chk({tag, ".addr"}, 64'(addrA), 64'(addr_tb[who]));
        chk({tag, ".din"}, 64'(dinA), 64'(data_tb[who]));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            addr_tb[i] = 9'h010 + 9'(i);
            data_tb[i] = 32'hA000_0000 + 32'(i);
        end
        tick();
        tick();
        chk("rst.enA", 64'(enA), 64'd0);
        chk("rst.weA", 64'(weA), 64'd0);
        chk("rst.addr", 64'(addrA), 64'd0);
        chk("rst.din", 64'(dinA), 64'd0);
        chk("rst.gid", 64'(grant_id), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst.ready_forced0", 64'(req_ready), 64'd0);
        tick();
        chk("rst.no_write", 64'(enA), 64'd0);

        // Round-robin over all four single-beat requesters.
        rst_n    = 1'b1;
        req_last = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(4'b0001 << k));
            tick();
            chk_beat($sformatf("rr%0d", k), k);
        end
        req_valid = 4'b0000;
        #1;
        chk("idle.ready", 64'(req_ready), 64'd0);
        tick();
        chk("idle.enA", 64'(enA), 64'd0);
        chk("idle.addr_hold", 64'(addrA), 64'(addr_tb[3]));
        chk("idle.gid_hold", 64'(grant_id), 64'd3);

        // Lone requester 2.
        addr_tb[2] = 9'h1A5;
        data_tb[2] = 32'hDEADBEEF;
        req_valid  = 4'b0100;
        #1;
        chk("solo2.ready", 64'(req_ready), 64'b0100);
        tick();
        chk_beat("solo2", 2);
        req_valid = 4'b0000;

`ifdef MEM_WR_ARB_BURST_EN
        // Move the pointer to 1, then requester 1 bursts 3 beats while 0 waits.
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0011;
        req_last  = 4'b0000;
        #1;
        chk("bst.b1.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_beat("bst.b1", 1);
        chk("bst.b1.busy", 64'(busy), 64'd1);
        #1;
        chk("bst.b2.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_beat("bst.b2", 1);
        chk("bst.b2.busy", 64'(busy), 64'd1);
        req_last = 4'b0011;
        #1;
        chk("bst.b3.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_beat("bst.b3", 1);
        chk("bst.b3.busy", 64'(busy), 64'd0);
        #1;
        chk("bst.r0.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_beat("bst.r0", 0);

        // Owner 1 stalls for two cycles mid-burst; requester 2 stays blocked.
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        #1;
        chk("stl.b1.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_beat("stl.b1", 1);
        req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("stl.gap%0d.ready", k), 64'(req_ready), 64'd0);
            tick();
            chk($sformatf("stl.gap%0d.enA", k), 64'(enA), 64'd0);
            chk($sformatf("stl.gap%0d.busy", k), 64'(busy), 64'd1);
        end
        req_valid = 4'b0110;
        req_last  = 4'b0010;
        #1;
        chk("stl.b2.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_beat("stl.b2", 1);
        chk("stl.b2.busy", 64'(busy), 64'd0);
        req_valid = 4'b0000;
`endif

        // Reset in the middle of a burst from requester 2.
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        #1;
        chk("mrst.ready", 64'(req_ready), 64'b0100);
        tick();
        chk_beat("mrst.b1", 2);
        chk("mrst.busy", 64'(busy), 64'(BURST));
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mrst.ready_forced0", 64'(req_ready), 64'd0);
        tick();
        chk("mrst.busy0", 64'(busy), 64'd0);
        chk("mrst.enA0", 64'(enA), 64'd0);
        chk("mrst.gid0", 64'(grant_id), 64'd0);
        chk("mrst.addr0", 64'(addrA), 64'd0);
        rst_n    = 1'b1;
        req_last = 4'b1111;
        #1;
        chk("mrst.r0.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_beat("mrst.r0", 0);
        req_valid = 4'b0000;

`ifndef MEM_WR_ARB_BURST_EN
        // req_last ignored: two requesters strictly alternate from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        req_last  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("alt%0d.ready", k), 64'(req_ready), (k % 2 == 0) ? 64'b0001 : 64'b0010);
            tick();
            chk_beat($sformatf("alt%0d", k), k % 2);
            chk($sformatf("alt%0d.busy", k), 64'(busy), 64'd0);
        end
        req_valid = 4'b0000;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
